// File: rtl/j1_boot_pkg.sv
// j1 boot loader shared types.
// State encoding, error codes and default frame marker.
package j1_boot_pkg;

  typedef enum logic [3:0] {
    ST_SYNC,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_WRITE,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CSUM    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_COUNT   = 2'b11
  } err_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/j1_boot_timer.sv
// Inactivity counter for the boot loader.
// Raises expire_o while enabled and the count sits at TIMEOUT-1.
module j1_boot_timer #(
  parameter int TIMEOUT = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmr_q, tmr_d;

  assign expire_o = en_i && (tmr_q == TW'(TIMEOUT - 1));

  always_comb begin
    tmr_d = tmr_q;
    if (clr_i) begin
      tmr_d = '0;
    end else if (en_i && !expire_o) begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

endmodule

// File: rtl/j1_boot_ctrl.sv
// j1 boot sequencer: loads a framed image into program RAM,
// checks its XOR checksum and releases the CPU from reset.
module j1_boot_ctrl
  import j1_boot_pkg::*;
#(
  parameter int          ADDR_W    = 13,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int          TIMEOUT   = 50_000_000
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic              boot_req_i,
  output logic              cpu_rst_o,
  output logic              ld_we_o,
  output logic [ADDR_W-1:0] ld_addr_o,
  output logic [15:0]       ld_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o
);

  localparam int CW = ADDR_W + 1;

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     idx_inc;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       n16;
  logic              acc;
  logic              busy;
  logic              expire;
  logic              cnt_bad;

  assign rx_ready_o = state_q inside {ST_SYNC, ST_CNT_H, ST_CNT_L,
                                      ST_DATA_H, ST_DATA_L, ST_CSUM};
  assign busy       = state_q inside {ST_CNT_H, ST_CNT_L, ST_DATA_H,
                                      ST_DATA_L, ST_WRITE, ST_CSUM};
  assign acc        = rx_valid_i & rx_ready_o;

  assign n16     = {hi_q, rx_data_i};
  assign cnt_bad = (n16 == 16'd0) || (32'(n16) > (32'd1 << ADDR_W));
  assign idx_inc = idx_q + CW'(1);

  assign cpu_rst_o = (state_q != ST_RUN);
  assign done_o    = (state_q == ST_RUN);
  assign busy_o    = busy;
  assign err_o     = err_q;
  assign ld_we_o   = we_q;
  assign ld_addr_o = addr_q;
  assign ld_data_o = data_q;

  // Held clear outside a load so every load starts from zero.
  j1_boot_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i    (sys_clk_i),
    .rst_ni   (sys_rst_i),
    .clr_i    (acc | ~busy),
    .en_i     (busy),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      ST_SYNC: begin
        if (acc && rx_data_i == SYNC_BYTE) begin
          state_d = ST_CNT_H;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      ST_CNT_H: begin
        if (acc) begin
          hi_d    = rx_data_i;
          state_d = ST_CNT_L;
        end
      end
      ST_CNT_L: begin
        if (acc) begin
          if (cnt_bad) begin
            state_d = ST_ERR;
            err_d   = ERR_COUNT;
          end else begin
            cnt_d   = CW'(n16);
            state_d = ST_DATA_H;
          end
        end
      end
      ST_DATA_H: begin
        if (acc) begin
          hi_d    = rx_data_i;
          csum_d  = csum_q ^ rx_data_i;
          state_d = ST_DATA_L;
        end
      end
      ST_DATA_L: begin
        if (acc) begin
          csum_d  = csum_q ^ rx_data_i;
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          data_d  = {hi_q, rx_data_i};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == cnt_q) ? ST_CSUM : ST_DATA_H;
      end
      ST_CSUM: begin
        if (acc) begin
          if (rx_data_i == csum_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
      ST_RUN, ST_ERR: begin
        if (boot_req_i) begin
          state_d = ST_SYNC;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = ST_SYNC;
    endcase
    // A byte accepted on the expiry cycle beats the timeout.
    if (expire && !acc) begin
      state_d = ST_ERR;
      err_d   = ERR_TIMEOUT;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q <= ST_SYNC;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// Directed bench for j1_boot_ctrl with a write scoreboard.
// Uses a short timeout so expiry is reachable.
module tb_j1_boot_ctrl;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready_o;
  logic          boot_req = 1'b0;
  logic          cpu_rst_o;
  logic          ld_we_o;
  logic [AW-1:0] ld_addr_o;
  logic [15:0]   ld_data_o;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    err_o;

  int total = 0;
  int bad = 0;
  logic [28:0] exp_q[$];
  logic [28:0] e;

  j1_boot_ctrl #(
    .ADDR_W    (AW),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (100)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready_o),
    .boot_req_i (boot_req),
    .cpu_rst_o  (cpu_rst_o),
    .ld_we_o    (ld_we_o),
    .ld_addr_o  (ld_addr_o),
    .ld_data_o  (ld_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ld_we_o !== 1'b0) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_write obs=%0h/%0h exp=none",
               ld_addr_o, ld_data_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write", {3'b0, ld_addr_o, ld_data_o}, {3'b0, e});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("ready_wait", {31'b0, rx_ready_o}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic word(input logic [AW-1:0] a, input logic [15:0] w);
    send(w[15:8]);
    exp_q.push_back({a, w});
    send(w[7:0]);
  endtask

  task automatic frame(input logic [7:0] cs);
    send(8'hA5);
    send(8'h00);
    send(8'h02);
    word(13'd0, 16'h1234);
    word(13'd1, 16'hABCD);
    send(cs);
  endtask

  task automatic boot();
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("idle_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
    chk("idle_ready", {31'b0, rx_ready_o}, 32'd1);
    chk("idle_we", {31'b0, ld_we_o}, 32'd0);
    chk("idle_done", {31'b0, done_o}, 32'd0);
    chk("idle_err", {30'b0, err_o}, 32'd0);
    chk("idle_busy", {31'b0, busy_o}, 32'd0);

    send(8'h00);
    send(8'hFF);
    chk("junk_busy", {31'b0, busy_o}, 32'd0);
    send(8'hA5);
    chk("sync_busy", {31'b0, busy_o}, 32'd1);
    send(8'h00);
    send(8'h02);
    word(13'd0, 16'h1234);
    word(13'd1, 16'hABCD);
    chk("pre_csum_rst", {31'b0, cpu_rst_o}, 32'd1);
    send(8'h40);
    chk("run_cpu_rst", {31'b0, cpu_rst_o}, 32'd0);
    chk("run_done", {31'b0, done_o}, 32'd1);
    chk("run_err", {30'b0, err_o}, 32'd0);
    chk("run_busy", {31'b0, busy_o}, 32'd0);
    chk("run_ready", {31'b0, rx_ready_o}, 32'd0);
    repeat (5) @(negedge clk);
    chk("run_q_empty", exp_q.size(), 32'd0);

    boot();
    chk("reboot_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
    chk("reboot_done", {31'b0, done_o}, 32'd0);
    chk("reboot_ready", {31'b0, rx_ready_o}, 32'd1);

    frame(8'h41);
    chk("csum_err", {30'b0, err_o}, 32'd1);
    chk("csum_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
    chk("csum_ready", {31'b0, rx_ready_o}, 32'd0);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    chk("csum_err_held", {30'b0, err_o}, 32'd1);
    boot();
    chk("csum_clear", {30'b0, err_o}, 32'd0);
    chk("csum_clear_rst", {31'b0, cpu_rst_o}, 32'd1);
    frame(8'h40);
    chk("reboot_done2", {31'b0, done_o}, 32'd1);
    boot();

    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    repeat (99) @(negedge clk);
    chk("to_before", {30'b0, err_o}, 32'd0);
    chk("to_before_busy", {31'b0, busy_o}, 32'd1);
    @(negedge clk);
    chk("to_err", {30'b0, err_o}, 32'd2);
    chk("to_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
    chk("to_busy", {31'b0, busy_o}, 32'd0);
    boot();

    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    repeat (99) @(negedge clk);
    exp_q.push_back({13'd0, 16'h1234});
    send(8'h34);
    chk("to_race_err", {30'b0, err_o}, 32'd0);
    send(8'h26);
    chk("to_race_done", {31'b0, done_o}, 32'd1);
    boot();

    send(8'hA5);
    send(8'h00);
    send(8'h00);
    chk("cnt_zero", {30'b0, err_o}, 32'd3);
    boot();
    send(8'hA5);
    send(8'h20);
    send(8'h01);
    chk("cnt_big", {30'b0, err_o}, 32'd3);
    boot();
    send(8'hA5);
    send(8'h20);
    send(8'h00);
    chk("cnt_max_err", {30'b0, err_o}, 32'd0);
    chk("cnt_max_busy", {31'b0, busy_o}, 32'd1);

    send(8'h12);
    rx_data  = 8'h34;
    rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
    chk("arst_we", {31'b0, ld_we_o}, 32'd0);
    chk("arst_addr", {19'b0, ld_addr_o}, 32'd0);
    chk("arst_data", {16'b0, ld_data_o}, 32'd0);
    chk("arst_busy", {31'b0, busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk("arst_resume_busy", {31'b0, busy_o}, 32'd0);
    chk("arst_q_empty", exp_q.size(), 32'd0);
    frame(8'h40);
    chk("final_done", {31'b0, done_o}, 32'd1);
    repeat (3) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
